// File: rtl/multicycle_control.sv
// Main controller for a multi-cycle MIPS datapath.
// Moore-style sequencer: the outputs decode the current state, and a few of them also use mem_ready.
// The R-type ALU code is captured in DECODE so that EXEC does not depend on Funct later.
module multicycle_control #(
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110,
    parameter logic [2:0] ALU_AND = 3'b000,
    parameter logic [2:0] ALU_OR  = 3'b001,
    parameter logic [2:0] ALU_SLT = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t     cur_state;
    state_t     next_state;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic [2:0] rtype_alu;

    assign state = cur_state;

    // Map Funct to an ALU code and flag the unsupported encodings
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register and the R-type ALU code captured in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= FETCH;
            rtype_alu <= ALU_ADD;
        end else begin
            cur_state <= next_state;
            if (cur_state == DECODE) begin
                rtype_alu <= funct_alu;
            end
        end
    end

    // Next-state logic and output decode; reset masks every enable
    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        illegal    = 1'b0;

        case (cur_state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            next_state = EXEC;
                        end else begin
                            illegal    = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_BEQ:  next_state = BRANCH;
                    OP_ADDI: next_state = ADDIEX;
                    OP_J:    next_state = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                next_state = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = rtype_alu;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        if (rst) begin
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream with random memory stalls.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, br, iord, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        logic       ill;
    } ctl_t;

    ctl_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word for one cycle of a given phase
    function automatic ctl_t model(input logic [3:0] st, input logic mr, input logic r,
                                   input logic [2:0] code, input logic ill);
        ctl_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd0:  begin e.asb = 2'b01; e.alu = 3'b010; e.irw = mr; e.pcw = mr; end
            4'd1:  begin e.asb = 2'b11; e.alu = 3'b010; e.ill = ill; end
            4'd2:  begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010; end
            4'd3:  begin e.iord = 1'b1; end
            4'd4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.asa = 1'b1; e.asb = 2'b00; e.alu = code; end
            4'd7:  begin e.rd = 1'b1; e.rw = 1'b1; end
            4'd8:  begin e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01; e.br = 1'b1; end
            4'd9:  begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010; end
            4'd10: begin e.rw = 1'b1; end
            4'd11: begin e.pcs = 2'b10; e.pcw = 1'b1; end
            default: ;
        endcase
        if (r) begin
            e.pcw = 1'b0; e.br = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs and queue the control word expected in that cycle
    task automatic cyc(input logic [3:0] st, input logic mr, input logic r,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [2:0] code, input logic ill);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = mr;
        Op = op;
        Funct = fn;
        exp_q.push_back(model(st, mr, r, code, ill));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal_fn(input logic [5:0] fn);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    function automatic logic [2:0] fn_code(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    // One instruction: cls 0=R 1=lw 2=sw 3=beq 4=addi 5=j 6=bad op 7=bad funct.
    // sf/sm are stall cycles in fetch/memory; rst_k>=0 resets during that MEMWR stall cycle.
    task automatic run(input int cls, input logic [5:0] fn_in, input int sf, input int sm, input int rst_k);
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] code;
        logic       ill;
        fn = fn_in;
        ill = 1'b0;
        case (cls)
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: begin
                op = 6'($urandom);
                while (legal_op(op)) op = 6'($urandom);
                ill = 1'b1;
            end
            default: begin
                op = 6'b000000;
                while (legal_fn(fn)) fn = 6'($urandom);
                ill = 1'b1;
            end
        endcase
        code = fn_code(fn);
        for (int i = 0; i < sf; i++) cyc(4'd0, 1'b0, 1'b0, 6'($urandom), 6'($urandom), code, 1'b0);
        cyc(4'd0, 1'b1, 1'b0, 6'($urandom), 6'($urandom), code, 1'b0);
        cyc(4'd1, rbit(), 1'b0, op, fn, code, ill);
        if (ill) return;
        case (cls)
            0: begin
                cyc(4'd6, rbit(), 1'b0, op, fn, code, 1'b0);
                cyc(4'd7, rbit(), 1'b0, op, fn, code, 1'b0);
            end
            1: begin
                cyc(4'd2, rbit(), 1'b0, op, fn, code, 1'b0);
                for (int i = 0; i < sm; i++) cyc(4'd3, 1'b0, 1'b0, op, fn, code, 1'b0);
                cyc(4'd3, 1'b1, 1'b0, op, fn, code, 1'b0);
                cyc(4'd4, rbit(), 1'b0, op, fn, code, 1'b0);
            end
            2: begin
                cyc(4'd2, rbit(), 1'b0, op, fn, code, 1'b0);
                for (int i = 0; i < sm; i++) begin
                    if (i == rst_k) begin
                        cyc(4'd5, 1'b0, 1'b1, op, fn, code, 1'b0);
                        return;
                    end
                    cyc(4'd5, 1'b0, 1'b0, op, fn, code, 1'b0);
                end
                cyc(4'd5, 1'b1, 1'b0, op, fn, code, 1'b0);
            end
            3: cyc(4'd8, rbit(), 1'b0, op, fn, code, 1'b0);
            4: begin
                cyc(4'd9, rbit(), 1'b0, op, fn, code, 1'b0);
                cyc(4'd10, rbit(), 1'b0, op, fn, code, 1'b0);
            end
            default: cyc(4'd11, rbit(), 1'b0, op, fn, code, 1'b0);
        endcase
    endtask

    // Monitor: compare the DUT control word against the queued expectation every cycle
    initial begin
        ctl_t a;
        ctl_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                     RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL ctl t=%0t state: got %0d want %0d word: got %h want %h",
                             $time, a.st, e.st, a, e);
                end
            end
        end
    end

    // Stimulus: directed cases from the plan, then a random instruction stream
    initial begin
        logic [5:0] fn_tab[5];
        fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
        fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;

        @(posedge clk);
        cyc(4'd0, 1'b1, 1'b1, 6'd0, 6'd0, 3'b010, 1'b0);
        cyc(4'd0, 1'b1, 1'b1, 6'd0, 6'd0, 3'b010, 1'b0);

        run(0, 6'b100010, 0, 0, -1);
        run(1, 6'd0, 0, 2, -1);
        run(2, 6'd0, 1, 3, -1);
        run(3, 6'd0, 0, 0, -1);
        run(5, 6'd0, 0, 0, -1);
        run(4, 6'd0, 0, 0, -1);
        run(6, 6'd0, 0, 0, -1);
        run(7, 6'b000111, 0, 0, -1);
        run(2, 6'd0, 0, 3, 1);

        for (int n = 0; n < 400; n++) begin
            int cls;
            int rk;
            cls = $urandom_range(0, 7);
            rk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            run(cls, fn_tab[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 3), rk);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main controller for a multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, IR, A/B/ALUOut/MDR registers.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, driving the mux selects and write enables.
- Stalls on a memory ready handshake.
- Instruction set: add, sub, and, or, slt, lw, sw, beq, addi, j. ALU encodings are identical to the single-cycle control unit.

Parameters:
- ALU_ADD, 3'b010, ALU add code
- ALU_SUB, 3'b110, ALU subtract code (also beq compare)
- ALU_AND, 3'b000, ALU and code
- ALU_OR, 3'b001, ALU or code
- ALU_SLT, 3'b111, ALU set-less-than code

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  IR[31:26]; valid from the DECODE state onward
- Funct  in  6  IR[5:0]; valid from the DECODE state onward
- mem_ready  in  1  memory access completes in the current cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ALU Zero (PCWriteCond)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUControl  out  3  ALU operation code
- illegal  out  1  one-cycle pulse on an unsupported Op/Funct
- state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 return to FETCH on the next edge with all outputs 0.
- Outputs are a combinational decode of state (plus mem_ready where stated). Any output not listed for a state is 0.
- While rst=1: PCWrite, Branch, MemWrite, IRWrite, RegWrite and illegal are forced to 0. The next state is FETCH.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (precomputes the branch target).
  - Registers the R-type ALU code from Funct: 100000 = ADD, 100010 = SUB, 100100 = AND, 100101 = OR, 101010 = SLT.
  - Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 with a valid Funct -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
  - Any other Op, or Op=000000 with an unlisted Funct: illegal=1 for this cycle, next state FETCH, no architectural state written.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Waits while mem_ready=0, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1, held every cycle until mem_ready=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl = the code registered in DECODE. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- Instruction latency with mem_ready held at 1: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3. Each mem_ready=0 cycle adds exactly one cycle.
- rst in any state, including mid-stall, returns to FETCH on that edge. No write enable is asserted during the reset cycle.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 -> all enables 0 during reset; the cycle after release shows state=0, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010.
- Op=000000, Funct=100010 (sub), mem_ready=1 -> state sequence 0,1,6,7,0; ALUControl=110 in EXEC; RegWrite=1 and RegDst=1 only in ALUWB.
- lw (Op=100011) with mem_ready=0 for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; IorD=1 throughout MEMRD; MemtoReg=1 and RegWrite=1 in MEMWB.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite stays 0 for the whole instruction.
- beq, then j, then addi (Op=001000) -> BRANCH shows Branch=1, PCSrc=01, ALUControl=110; JUMP shows PCWrite=1, PCSrc=10; addi sequence is 0,1,9,10,0.
- Op=111111, then Op=000000 with Funct=000111 -> illegal=1 for exactly one cycle in DECODE each time, then FETCH.
- rst asserted while waiting in MEMWR -> MemWrite=0 that cycle; state=0 after the edge.
